// File: rtl/core_seq_ctrl_if.sv
// Host/core-facing signals of the conv-layer instruction sequencer.
// The host drives start, mode and OFIFO status; the sequencer drives the inst word and status.
interface core_seq_ctrl_if;
  logic        start;
  logic        mode_in;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        acc_clr;
  logic        busy;
  logic        done;

  modport master (output start, mode_in, ofifo_valid, input inst, acc_clr, busy, done);
  modport slave  (input start, mode_in, ofifo_valid, output inst, acc_clr, busy, done);
endinterface

// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one conv layer: nine kij passes into pmem, then
// the per-output accumulation pass. Every output, including inst, is registered.
//
// state      | meaning
// IDLE       | waiting for start
// W_L0       | weight tile row i from xmem into L0
// W_LOAD     | weights from L0 into the PEs
// X_L0       | activations from xmem into L0
// EXEC       | stream activations through the array
// FLUSH      | drain the array
// OFIFO      | move LEN_NIJ psums from OFIFO to pmem, gated by ofifo_valid
// ACC_CLR    | clear the SFP accumulator
// ACC_RD     | read the nine psums of output o
// ACC_TAIL   | accumulate the final read
// DONE       | one-cycle done pulse
module core_seq_ctrl #(
  parameter int COL       = 8,
  parameter int ROW       = 8,
  parameter int IW        = 6,
  parameter int K         = 3,
  parameter int W_BASE    = 1024,
  parameter int PSUM_BASE = 0
) (
  input  logic            clk,
  input  logic            reset,
  core_seq_ctrl_if.slave  bus
);

  localparam int OW       = IW - K + 1;
  localparam int LEN_NIJ  = IW * IW;
  localparam int LEN_ONIJ = OW * OW;
  localparam int LEN_KIJ  = K * K;

  localparam logic [6:0] ST_OFRD = 7'b1000000;
  localparam logic [6:0] ST_L0RD = 7'b0001000;
  localparam logic [6:0] ST_L0WR = 7'b0000100;
  localparam logic [6:0] ST_EXE  = 7'b0000010;
  localparam logic [6:0] ST_LOAD = 7'b0000001;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_X_L0, S_EXEC, S_FLUSH,
    S_OFIFO, S_ACC_CLR, S_ACC_RD, S_ACC_TAIL, S_DONE
  } state_t;

  state_t      state;
  logic        mode_q;
  logic [3:0]  kij;
  logic [10:0] cnt;
  logic [7:0]  o_row, o_col, ki, kj, j;
  logic [34:0] inst_q;
  logic        acc_clr_q, busy_q, done_q;
  logic [10:0] w_addr, p_wr_addr, p_rd_addr;

  // {mode, acc, CEN_p, WEN_p, A_p, CEN_x, WEN_x (always read), A_x, strobes}
  function automatic logic [34:0] word(input logic m, input logic acc, input logic cen_p,
                                       input logic wen_p, input logic [10:0] a_p,
                                       input logic cen_x, input logic [10:0] a_x,
                                       input logic [6:0] str);
    return {m, acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, str};
  endfunction

  assign w_addr    = 11'(W_BASE + 32'(kij) * COL + 32'(cnt));
  assign p_wr_addr = 11'(PSUM_BASE + 32'(kij) * LEN_NIJ + 32'(cnt));
  assign p_rd_addr = 11'(PSUM_BASE + 32'(j) * LEN_NIJ + (32'(o_row) + 32'(ki)) * IW
                         + 32'(o_col) + 32'(kj));

  assign bus.inst    = inst_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      kij       <= '0;
      cnt       <= '0;
      o_row     <= '0;
      o_col     <= '0;
      ki        <= '0;
      kj        <= '0;
      j         <= '0;
      inst_q    <= word(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 7'd0);
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inst_q    <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 7'd0);
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode_in;
            inst_q <= word(bus.mode_in, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 7'd0);
            busy_q <= 1'b1;
            kij    <= '0;
            cnt    <= '0;
            state  <= S_W_L0;
          end
        end
        S_W_L0: begin
          inst_q <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, w_addr, ST_L0WR);
          if (cnt == 11'(COL - 1)) begin
            cnt   <= '0;
            state <= S_W_LOAD;
          end else cnt <= cnt + 11'd1;
        end
        S_W_LOAD: begin
          inst_q <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, ST_L0RD | ST_LOAD);
          if (cnt == 11'(COL - 1)) begin
            cnt   <= '0;
            state <= S_X_L0;
          end else cnt <= cnt + 11'd1;
        end
        S_X_L0: begin
          inst_q <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, cnt, ST_L0WR);
          if (cnt == 11'(LEN_NIJ - 1)) begin
            cnt   <= '0;
            state <= S_EXEC;
          end else cnt <= cnt + 11'd1;
        end
        S_EXEC: begin
          inst_q <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, ST_L0RD | ST_EXE);
          if (cnt == 11'(LEN_NIJ - 1)) begin
            cnt   <= '0;
            state <= S_FLUSH;
          end else cnt <= cnt + 11'd1;
        end
        S_FLUSH: begin
          inst_q <= word(mode_q, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, ST_L0RD | ST_EXE);
          if (cnt == 11'(ROW + COL - 1)) begin
            cnt   <= '0;
            state <= S_OFIFO;
          end else cnt <= cnt + 11'd1;
        end
        S_OFIFO: begin
          // A cycle without ofifo_valid keeps the idle word and holds the count.
          if (bus.ofifo_valid) begin
            inst_q <= word(mode_q, 1'b0, 1'b0, 1'b0, p_wr_addr, 1'b1, 11'd0, ST_OFRD);
            if (cnt == 11'(LEN_NIJ - 1)) begin
              cnt <= '0;
              kij <= kij + 4'd1;
              if (kij == 4'(LEN_KIJ - 1)) begin
                o_row <= '0;
                o_col <= '0;
                state <= S_ACC_CLR;
              end else state <= S_W_L0;
            end else cnt <= cnt + 11'd1;
          end
        end
        S_ACC_CLR: begin
          acc_clr_q <= 1'b1;
          j         <= '0;
          ki        <= '0;
          kj        <= '0;
          state     <= S_ACC_RD;
        end
        S_ACC_RD: begin
          // acc trails the read by one cycle to cover pmem read latency.
          inst_q <= word(mode_q, (j != 8'd0), 1'b0, 1'b1, p_rd_addr, 1'b1, 11'd0, 7'd0);
          if (kj == 8'(K - 1)) begin
            kj <= '0;
            ki <= ki + 8'd1;
          end else kj <= kj + 8'd1;
          j <= j + 8'd1;
          if (j == 8'(LEN_KIJ - 1)) state <= S_ACC_TAIL;
        end
        S_ACC_TAIL: begin
          inst_q <= word(mode_q, 1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 7'd0);
          state  <= S_ACC_CLR;
          if (o_col == 8'(OW - 1)) begin
            o_col <= '0;
            if (o_row == 8'(OW - 1)) state <= S_DONE;
            else o_row <= o_row + 8'd1;
          end else o_col <= o_col + 8'd1;
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
